// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control FSM: opcodes, functs, states,
// ALU operations, mux selects and fault codes.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [3:0] {
        StFetch  = 4'd0,
        StDecode = 4'd1,
        StMemAdr = 4'd2,
        StMemRd  = 4'd3,
        StMemWb  = 4'd4,
        StMemWr  = 4'd5,
        StExec   = 4'd6,
        StAluWb  = 4'd7,
        StBranch = 4'd8,
        StJump   = 4'd9,
        StAddiEx = 4'd10,
        StAddiWb = 4'd11,
        StHalt   = 4'd15
    } state_e;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] FAULT_NONE    = 2'b00;
    localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
    localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

endpackage

// File: rtl/mips_alu_decode.sv
// R-type funct decoder: selects the ALU operation and flags unsupported functs.
module mips_alu_decode
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] funct_i,
    output logic [2:0] alu_ctrl_o,
    output logic       illegal_o
);

    always_comb begin
        alu_ctrl_o = ALU_ADD;
        illegal_o  = 1'b0;
        case (funct_i)
            FN_ADD:  alu_ctrl_o = ALU_ADD;
            FN_SUB:  alu_ctrl_o = ALU_SUB;
            FN_AND:  alu_ctrl_o = ALU_AND;
            FN_OR:   alu_ctrl_o = ALU_OR;
            FN_SLT:  alu_ctrl_o = ALU_SLT;
            default: illegal_o  = 1'b1;
        endcase
    end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Main control FSM of the multi-cycle MIPS datapath: sequences fetch/decode/execute/
// memory/writeback, waits on mem_ready and halts on illegal instructions or timeouts.
module mips_mc_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [5:0] op_i,
    input  logic [5:0] funct_i,
    input  logic       zero_i,
    input  logic       mem_ready_i,
    output logic       pc_en_o,
    output logic       iord_o,
    output logic       mem_read_o,
    output logic       mem_write_o,
    output logic       ir_write_o,
    output logic       reg_dst_o,
    output logic       mem_to_reg_o,
    output logic       reg_write_o,
    output logic       alu_src_a_o,
    output logic [1:0] alu_src_b_o,
    output logic [2:0] alu_ctrl_o,
    output logic [1:0] pc_src_o,
    output logic [3:0] state_o,
    output logic       halted_o,
    output logic [1:0] fault_o
);

    localparam logic [7:0] TimeoutCnt = 8'(MEM_TIMEOUT);

    state_e     state_q, state_d;
    logic [7:0] wait_q, wait_d;
    logic [1:0] fault_q, fault_d;
    logic [2:0] rtype_ctrl;
    logic       rtype_illegal;
    logic       mem_wait;

    mips_alu_decode u_alu_decode (
        .funct_i    (funct_i),
        .alu_ctrl_o (rtype_ctrl),
        .illegal_o  (rtype_illegal)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StFetch;
            wait_q  <= 8'd0;
            fault_q <= FAULT_NONE;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            fault_q <= fault_d;
        end
    end

    assign mem_wait = ((state_q == StFetch) || (state_q == StMemRd) || (state_q == StMemWr))
                      && !mem_ready_i;

    always_comb begin
        state_d      = state_q;
        fault_d      = fault_q;
        pc_en_o      = 1'b0;
        iord_o       = 1'b0;
        mem_read_o   = 1'b0;
        mem_write_o  = 1'b0;
        ir_write_o   = 1'b0;
        reg_dst_o    = 1'b0;
        mem_to_reg_o = 1'b0;
        reg_write_o  = 1'b0;
        alu_src_a_o  = 1'b0;
        alu_src_b_o  = SRCB_REG;
        alu_ctrl_o   = ALU_ADD;
        pc_src_o     = PCSRC_ALU;

        case (state_q)
            StFetch: begin
                mem_read_o  = 1'b1;
                alu_src_b_o = SRCB_FOUR;
                pc_en_o     = mem_ready_i;
                ir_write_o  = mem_ready_i;
                if (mem_ready_i) state_d = StDecode;
            end
            StDecode: begin
                alu_src_b_o = SRCB_IMM_SH;
                case (op_i)
                    OP_RTYPE:     state_d = StExec;
                    OP_LW, OP_SW: state_d = StMemAdr;
                    OP_BEQ, OP_BNE: state_d = StBranch;
                    OP_J:         state_d = StJump;
                    OP_ADDI:      state_d = StAddiEx;
                    default: begin
                        state_d = StHalt;
                        fault_d = FAULT_ILLEGAL;
                    end
                endcase
            end
            StMemAdr: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = SRCB_IMM;
                state_d     = (op_i == OP_LW) ? StMemRd : StMemWr;
            end
            StMemRd: begin
                mem_read_o = 1'b1;
                iord_o     = 1'b1;
                if (mem_ready_i) state_d = StMemWb;
            end
            StMemWb: begin
                reg_write_o  = 1'b1;
                mem_to_reg_o = 1'b1;
                state_d      = StFetch;
            end
            StMemWr: begin
                mem_write_o = 1'b1;
                iord_o      = 1'b1;
                if (mem_ready_i) state_d = StFetch;
            end
            StExec: begin
                alu_src_a_o = 1'b1;
                alu_ctrl_o  = rtype_ctrl;
                if (rtype_illegal) begin
                    state_d = StHalt;
                    fault_d = FAULT_ILLEGAL;
                end else begin
                    state_d = StAluWb;
                end
            end
            StAluWb: begin
                alu_src_a_o = 1'b1;
                alu_ctrl_o  = rtype_ctrl;
                reg_write_o = 1'b1;
                reg_dst_o   = 1'b1;
                state_d     = StFetch;
            end
            StBranch: begin
                alu_src_a_o = 1'b1;
                alu_ctrl_o  = ALU_SUB;
                pc_src_o    = PCSRC_ALUOUT;
                pc_en_o     = (op_i == OP_BEQ) ? zero_i : !zero_i;
                state_d     = StFetch;
            end
            StJump: begin
                pc_src_o = PCSRC_JUMP;
                pc_en_o  = 1'b1;
                state_d  = StFetch;
            end
            StAddiEx: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = SRCB_IMM;
                state_d     = StAddiWb;
            end
            StAddiWb: begin
                reg_write_o = 1'b1;
                state_d     = StFetch;
            end
            default: state_d = StHalt;
        endcase

        // Timeout is checked against the count before this cycle's increment.
        if (mem_wait && (wait_q == TimeoutCnt)) begin
            state_d = StHalt;
            fault_d = FAULT_TIMEOUT;
        end

        if (state_d != state_q) wait_d = 8'd0;
        else if (mem_wait)      wait_d = wait_q + 8'd1;
        else                    wait_d = wait_q;

        if (rst_i) begin
            pc_en_o      = 1'b0;
            iord_o       = 1'b0;
            mem_read_o   = 1'b0;
            mem_write_o  = 1'b0;
            ir_write_o   = 1'b0;
            reg_dst_o    = 1'b0;
            mem_to_reg_o = 1'b0;
            reg_write_o  = 1'b0;
            alu_src_a_o  = 1'b0;
            alu_src_b_o  = SRCB_REG;
            alu_ctrl_o   = ALU_ADD;
            pc_src_o     = PCSRC_ALU;
        end
    end

    assign state_o  = state_q;
    assign halted_o = (state_q == StHalt);
    assign fault_o  = fault_q;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Directed bench for mips_mc_ctrl: walks each instruction class cycle by cycle and
// compares state and strobes against hand-computed values.
module tb_mips_mc_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       pc_en, iord, mem_read, mem_write, ir_write;
    logic       reg_dst, mem_to_reg, reg_write, alu_src_a, halted;
    logic [1:0] alu_src_b, pc_src, fault;
    logic [2:0] alu_ctrl;
    logic [3:0] state;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mips_mc_ctrl #(.MEM_TIMEOUT(15)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .op_i         (op),
        .funct_i      (funct),
        .zero_i       (zero),
        .mem_ready_i  (mem_ready),
        .pc_en_o      (pc_en),
        .iord_o       (iord),
        .mem_read_o   (mem_read),
        .mem_write_o  (mem_write),
        .ir_write_o   (ir_write),
        .reg_dst_o    (reg_dst),
        .mem_to_reg_o (mem_to_reg),
        .reg_write_o  (reg_write),
        .alu_src_a_o  (alu_src_a),
        .alu_src_b_o  (alu_src_b),
        .alu_ctrl_o   (alu_ctrl),
        .pc_src_o     (pc_src),
        .state_o      (state),
        .halted_o     (halted),
        .fault_o      (fault)
    );

    // {pc_en, mem_read, mem_write, ir_write, reg_write}
    wire [4:0] strobes = {pc_en, mem_read, mem_write, ir_write, reg_write};

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Check state and strobes in the current cycle, then advance one clock.
    task automatic cyc(input string tag, input logic [3:0] st, input logic [4:0] sb);
        #1;
        check({tag, ".state"}, 8'(state), 8'(st));
        check({tag, ".strb"}, 8'(strobes), 8'(sb));
        step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        mem_ready = 1'b1;
        zero = 1'b0;
        op = 6'h00;
        funct = 6'h20;
        step();
        step();
        check("rst.strb", 8'(strobes), 8'h00);
        check("rst.state", 8'(state), 8'h00);
        check("rst.fault", 8'(fault), 8'h00);
        check("rst.halted", 8'(halted), 8'h00);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        op = 6'h00;
        funct = 6'h00;
        zero = 1'b0;
        mem_ready = 1'b0;
        #2;
        check("rst.async", 8'(strobes), 8'h00);

        // add $3,$1,$2
        do_reset();
        op = 6'h00; funct = 6'h20;
        cyc("add.fetch", 4'd0, 5'b11010);
        #1; check("add.dec.srcb", 8'(alu_src_b), 8'h3);
        cyc("add.dec", 4'd1, 5'b00000);
        #1; check("add.exec.alu", 8'(alu_ctrl), 8'h2);
        check("add.exec.srca", 8'(alu_src_a), 8'h1);
        cyc("add.exec", 4'd6, 5'b00000);
        #1; check("add.wb.regdst", 8'(reg_dst), 8'h1);
        cyc("add.wb", 4'd7, 5'b00001);
        cyc("add.next", 4'd0, 5'b11010);

        // sub in EXEC
        op = 6'h00; funct = 6'h22;
        cyc("sub.dec", 4'd1, 5'b00000);
        #1; check("sub.exec.alu", 8'(alu_ctrl), 8'h6);
        cyc("sub.exec", 4'd6, 5'b00000);
        cyc("sub.wb", 4'd7, 5'b00001);

        // lw with two wait cycles in MEMRD
        op = 6'h23;
        cyc("lw.fetch", 4'd0, 5'b11010);
        cyc("lw.dec", 4'd1, 5'b00000);
        cyc("lw.adr", 4'd2, 5'b00000);
        mem_ready = 1'b0;
        #1; check("lw.rd.iord", 8'(iord), 8'h1);
        cyc("lw.rd0", 4'd3, 5'b01000);
        cyc("lw.rd1", 4'd3, 5'b01000);
        mem_ready = 1'b1;
        cyc("lw.rd2", 4'd3, 5'b01000);
        #1; check("lw.wb.m2r", 8'(mem_to_reg), 8'h1);
        check("lw.wb.regdst", 8'(reg_dst), 8'h0);
        cyc("lw.wb", 4'd4, 5'b00001);

        // beq taken / not taken, bne taken
        op = 6'h04; zero = 1'b1;
        cyc("beq1.fetch", 4'd0, 5'b11010);
        cyc("beq1.dec", 4'd1, 5'b00000);
        #1; check("beq1.pcsrc", 8'(pc_src), 8'h1);
        check("beq1.alu", 8'(alu_ctrl), 8'h6);
        cyc("beq1.br", 4'd8, 5'b10000);
        zero = 1'b0;
        cyc("beq0.fetch", 4'd0, 5'b11010);
        cyc("beq0.dec", 4'd1, 5'b00000);
        cyc("beq0.br", 4'd8, 5'b00000);
        op = 6'h05;
        cyc("bne.fetch", 4'd0, 5'b11010);
        cyc("bne.dec", 4'd1, 5'b00000);
        cyc("bne.br", 4'd8, 5'b10000);

        // j
        op = 6'h02;
        cyc("j.fetch", 4'd0, 5'b11010);
        cyc("j.dec", 4'd1, 5'b00000);
        #1; check("j.pcsrc", 8'(pc_src), 8'h2);
        cyc("j.jmp", 4'd9, 5'b10000);

        // addi
        op = 6'h08;
        cyc("addi.fetch", 4'd0, 5'b11010);
        cyc("addi.dec", 4'd1, 5'b00000);
        #1; check("addi.ex.srcb", 8'(alu_src_b), 8'h2);
        cyc("addi.ex", 4'd10, 5'b00000);
        cyc("addi.wb", 4'd11, 5'b00001);

        // sw, then async reset while MEMWR waits
        op = 6'h2B;
        cyc("sw.fetch", 4'd0, 5'b11010);
        cyc("sw.dec", 4'd1, 5'b00000);
        cyc("sw.adr", 4'd2, 5'b00000);
        mem_ready = 1'b0;
        #1; check("sw.wr.strb", 8'(strobes), 8'h04);
        check("sw.wr.state", 8'(state), 8'h05);
        rst = 1'b1;
        #1; check("sw.rst.memwr", 8'(mem_write), 8'h0);
        check("sw.rst.state", 8'(state), 8'h00);
        step();
        rst = 1'b0;
        #1; check("sw.rel.fault", 8'(fault), 8'h00);
        mem_ready = 1'b1;
        cyc("sw.rel.fetch", 4'd0, 5'b11010);

        // illegal opcode
        do_reset();
        op = 6'h3F;
        cyc("ill.fetch", 4'd0, 5'b11010);
        cyc("ill.dec", 4'd1, 5'b00000);
        for (int i = 0; i < 20; i++) begin
            #1; check("ill.halted", 8'(halted), 8'h1);
            check("ill.fault", 8'(fault), 8'h1);
            cyc("ill.halt", 4'd15, 5'b00000);
        end

        // illegal funct
        do_reset();
        op = 6'h00; funct = 6'h27;
        cyc("fn.fetch", 4'd0, 5'b11010);
        cyc("fn.dec", 4'd1, 5'b00000);
        cyc("fn.exec", 4'd6, 5'b00000);
        #1; check("fn.fault", 8'(fault), 8'h1);
        check("fn.halted", 8'(halted), 8'h1);
        cyc("fn.halt", 4'd15, 5'b00000);

        // FETCH timeout: 16 waiting cycles then HALT
        do_reset();
        mem_ready = 1'b0;
        for (int i = 0; i < 16; i++) cyc("to.fetch", 4'd0, 5'b01000);
        #1; check("to.fault", 8'(fault), 8'h2);
        check("to.halted", 8'(halted), 8'h1);
        cyc("to.halt", 4'd15, 5'b00000);

        // ready arrives on the limit cycle: normal completion
        do_reset();
        mem_ready = 1'b0;
        for (int i = 0; i < 15; i++) cyc("lim.fetch", 4'd0, 5'b01000);
        mem_ready = 1'b1;
        cyc("lim.last", 4'd0, 5'b11010);
        #1; check("lim.fault", 8'(fault), 8'h0);
        check("lim.state", 8'(state), 8'h01);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
